// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: block RAM with registered read feeding a two-register prefetch stage.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 11,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  err_clr_i
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] count_t;
    localparam count_t DEPTH_C  = count_t'(DEPTH);
    localparam count_t AFULL_C  = count_t'(AFULL_THRESH);
    localparam count_t AEMPTY_C = count_t'(AEMPTY_THRESH);
    localparam count_t ONE_C    = count_t'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] stageData_q;
    logic [DATA_WIDTH-1:0] outData_q, outData_d;
    logic                  stageValid_q, stageValid_d;
    logic                  outValid_q, outValid_d;
    count_t                wrPtr_q, wrPtr_d;
    count_t                rdPtr_q, rdPtr_d;
    count_t                level_q, level_d;

    logic wrAccept, popAccept, ramHasData, outLoad, ramRead;

    // Level is the single source of truth for capacity, so words sitting in
    // the prefetch registers still count against DEPTH.
    assign wrAccept   = wr_en && (level_q != DEPTH_C);
    assign popAccept  = rd_en && outValid_q;
    assign ramHasData = (wrPtr_q != rdPtr_q);
    assign outLoad    = !outValid_q || popAccept;
    assign ramRead    = ramHasData && (!stageValid_q || outLoad);

    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        level_d      = level_q;
        stageValid_d = stageValid_q;
        outValid_d   = outValid_q;
        outData_d    = outData_q;

        if (wrAccept) wrPtr_d = wrPtr_q + ONE_C;
        if (ramRead)  rdPtr_d = rdPtr_q + ONE_C;

        if (wrAccept && !popAccept)      level_d = level_q + ONE_C;
        else if (popAccept && !wrAccept) level_d = level_q - ONE_C;

        if (outLoad) begin
            outValid_d = stageValid_q;
            if (stageValid_q) outData_d = stageData_q;
        end

        if (ramRead)      stageValid_d = 1'b1;
        else if (outLoad) stageValid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            stageValid_q <= 1'b0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            level_q      <= level_d;
            stageValid_q <= stageValid_d;
            outValid_q   <= outValid_d;
            outData_q    <= outData_d;
        end
    end

    // Reset-free storage and read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wrAccept) mem_q[wrPtr_q[ADDR_WIDTH-1:0]] <= din;
        if (ramRead)  stageData_q <= mem_q[rdPtr_q[ADDR_WIDTH-1:0]];
    end

    assign full         = (level_q == DEPTH_C);
    assign almost_full  = (level_q >= AFULL_C);
    assign almost_empty = (level_q <= AEMPTY_C);
    assign level        = level_q;
    assign valid        = outValid_q;
    assign empty        = !outValid_q;
    assign dout         = outData_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && full)       overflow_d = 1'b1;
        else if (err_clr_i)      overflow_d = 1'b0;
        if (rd_en && !outValid_q) underflow_d = 1'b1;
        else if (err_clr_i)       underflow_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    logic unusedErrClr;
    assign unusedErrClr = err_clr_i;
    assign overflow_o   = 1'b0;
    assign underflow_o  = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: vector table, directed corner sequences and a random run against a queue model.
// Flag expectations follow SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_fwft;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 4;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;
    logic          full, almost_full, valid, empty, almost_empty;
    logic          overflow_o, underflow_o;
    logic [DW-1:0] dout;
    logic [AW:0]   level;

    sync_fifo_fwft #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
    ) dut (
        .clk_i(clk), .rst_i(rst), .din(din), .wr_en(wr_en), .full(full),
        .almost_full(almost_full), .dout(dout), .valid(valid), .rd_en(rd_en),
        .empty(empty), .almost_empty(almost_empty), .level(level),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: queue of words tagged with the edge they were written;
    // a head word becomes visible two edges after its write.
    typedef struct { logic [DW-1:0] d; int t; } entry_t;
    entry_t mq[$];
    int     edgeNum = 0;
    logic   mVld = 1'b0, mOvf = 1'b0, mUnf = 1'b0, mRstDout = 1'b1;
    int     total = 0, bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic modelStep();
        logic   fullPre, vldPre;
        entry_t e;
        edgeNum++;
        fullPre = (mq.size() == DEPTH);
        vldPre  = mVld;
        if (rst) begin
            mq.delete();
            mOvf = 1'b0;
            mUnf = 1'b0;
            mRstDout = 1'b1;
        end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (wr_en && fullPre) mOvf = 1'b1;
            else if (err_clr)     mOvf = 1'b0;
            if (rd_en && !vldPre) mUnf = 1'b1;
            else if (err_clr)     mUnf = 1'b0;
`endif
            if (rd_en && vldPre) void'(mq.pop_front());
            if (wr_en && !fullPre) begin
                e.d = din;
                e.t = edgeNum;
                mq.push_back(e);
            end
        end
        mVld = (mq.size() > 0) && (mq[0].t + 2 <= edgeNum);
        if (mVld) mRstDout = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [DW-1:0] d,
                                 input logic rd, input logic c);
        rst = r; wr_en = w; din = d; rd_en = rd; err_clr = c;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        cmp("level", level, mq.size());
        cmp("valid", valid, mVld);
        cmp("empty", empty, !mVld);
        cmp("full", full, mq.size() == DEPTH);
        cmp("almost_full", almost_full, mq.size() >= AFT);
        cmp("almost_empty", almost_empty, mq.size() <= AET);
        if (mVld)          cmp("dout", dout, mq[0].d);
        else if (mRstDout) cmp("dout_reset", dout, 0);
        cmp("overflow", overflow_o, mOvf);
        cmp("underflow", underflow_o, mUnf);
    endtask

    typedef struct {
        logic r, w; logic [DW-1:0] d; logic rd, c;
        int lvl; logic vld; logic [DW-1:0] dat; logic unf;
    } vec_t;

    initial begin
        vec_t vecs[13];
        int   wrBias[5];
        int   rdBias[5];
        int   n;

        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].w, vecs[i].d, vecs[i].rd, vecs[i].c);
            checkOutput();
            cmp($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            cmp($sformatf("vec%0d_valid", i), valid, vecs[i].vld);
            if (vecs[i].vld) cmp($sformatf("vec%0d_dout", i), dout, vecs[i].dat);
            cmp($sformatf("vec%0d_underflow", i), underflow_o, ERR_EN ? vecs[i].unf : 1'b0);
        end

        // Fill to full one word at a time, watching both thresholds.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, i[DW-1:0], 1'b0, 1'b0);
            checkOutput();
            cmp($sformatf("fill%0d_aempty", i), almost_empty, (i + 1) <= AET);
            cmp($sformatf("fill%0d_afull", i), almost_full, (i + 1) >= AFT);
        end
        cmp("fill_full", full, 1);
        cmp("fill_level", level, DEPTH);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput();
        cmp("drop_level", level, DEPTH);
        cmp("drop_overflow", overflow_o, ERR_EN);

        // Drain in order; the first pop carries a write that full must reject.
        for (int k = 0; k < DEPTH; k++) begin
            cmp($sformatf("drain%0d_dout", k), dout, k);
            applyStimulus(1'b0, k == 0, 8'hEE, 1'b1, 1'b0);
            checkOutput();
        end
        cmp("drained_valid", valid, 0);
        cmp("drained_level", level, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput();

        // Prefill three, then stream write+pop every cycle across pointer wrap.
        n = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, n[DW-1:0], 1'b0, 1'b0);
            checkOutput();
            n++;
        end
        for (int j = 0; j < 100; j++) begin
            cmp($sformatf("stream%0d_dout", j), dout, j & 8'hFF);
            applyStimulus(1'b0, 1'b1, n[DW-1:0], 1'b1, 1'b0);
            checkOutput();
            cmp($sformatf("stream%0d_level", j), level, 3);
            cmp($sformatf("stream%0d_valid", j), valid, 1);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput();
        end

        // Reset mid-operation with both requests high, then a fresh write.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h10 + i[DW-1:0], 1'b0, 1'b0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput();
        cmp("rst_level", level, 0);
        cmp("rst_valid", valid, 0);
        cmp("rst_dout", dout, 0);
        cmp("rst_full", full, 0);
        cmp("rst_aempty", almost_empty, 1);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput();
        cmp("post_rst_valid", valid, 1);
        cmp("post_rst_dout", dout, 8'h77);

        // Random traffic in phases that push toward full and toward empty.
        wrBias = '{70, 30, 90, 20, 50};
        rdBias = '{30, 70, 20, 90, 50};
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 99) < wrBias[i / 100],
                          DW'($urandom),
                          $urandom_range(0, 99) < rdBias[i / 100],
                          $urandom_range(0, 19) == 0);
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
